// File: rtl/shim_fifo_pkg.sv
// Shared sizing for the sample packer and the BRAM FIFO it feeds.
package shim_fifo_pkg;
  localparam int DEF_SAMPLE_WIDTH     = 16;
  localparam int DEF_SAMPLES_PER_WORD = 2;

  // Lane index width, never narrower than one bit (SAMPLES_PER_WORD=1 still needs a counter).
  function automatic int lane_w(input int spw);
    return (spw <= 2) ? 1 : $clog2(spw);
  endfunction

  function automatic int data_w(input int sw, input int spw);
    return sw * spw;
  endfunction
endpackage

// File: rtl/sample_lane_assembler.sv
// Collects samples lane by lane and strobes a completed (zero-padded) word.
module sample_lane_assembler
  import shim_fifo_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = DEF_SAMPLE_WIDTH,
  parameter int SAMPLES_PER_WORD = DEF_SAMPLES_PER_WORD,
  localparam int LW              = lane_w(SAMPLES_PER_WORD)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [SAMPLE_WIDTH-1:0]                  in_data,
  input  logic                                     in_valid,
  input  logic                                     flush,
  output logic [SAMPLE_WIDTH*SAMPLES_PER_WORD-1:0] word,
  output logic                                     done,
  output logic [LW-1:0]                            lane
);
  localparam logic [LW-1:0] LAST = LW'(SAMPLES_PER_WORD - 1);

  logic [SAMPLES_PER_WORD-1:0][SAMPLE_WIDTH-1:0] asm_q, nxt;

  // Lanes at or above the counter are always zero, so the merged word is already padded.
  for (genvar k = 0; k < SAMPLES_PER_WORD; k++) begin : g_lane
    assign nxt[k] = (in_valid && lane == LW'(k)) ? in_data : asm_q[k];
  end

  assign word = nxt;
  assign done = (in_valid && lane == LAST) || (flush && (lane != '0 || in_valid));

  always_ff @(posedge clk) begin
    if (reset) begin
      lane  <= '0;
      asm_q <= '0;
    end else if (done) begin
      lane  <= '0;
      asm_q <= '0;
    end else if (in_valid) begin
      lane  <= lane + LW'(1);
      asm_q <= nxt;
    end
  end
endmodule

// File: rtl/fifo_sample_packer.sv
// Packs a free-running sample stream into FIFO words with a one-word skid and drop accounting.
module fifo_sample_packer
  import shim_fifo_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = DEF_SAMPLE_WIDTH,
  parameter int SAMPLES_PER_WORD = DEF_SAMPLES_PER_WORD,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [SAMPLE_WIDTH-1:0]                  in_data,
  input  logic                                     in_valid,
  input  logic                                     flush,
  input  logic                                     clear_status,
  output logic [SAMPLE_WIDTH*SAMPLES_PER_WORD-1:0] fifo_wr_data,
  output logic                                     fifo_wr_en,
  input  logic                                     fifo_full,
  output logic                                     overflow,
  output logic [CNT_WIDTH-1:0]                     drop_count,
  output logic [CNT_WIDTH-1:0]                     word_count,
  output logic                                     busy
);
  localparam int DATA_WIDTH = data_w(SAMPLE_WIDTH, SAMPLES_PER_WORD);
  localparam int LW         = lane_w(SAMPLES_PER_WORD);

  logic [DATA_WIDTH-1:0] word, pend_word;
  logic                  done, pend_valid, drop;
  logic [LW-1:0]         lane;

  sample_lane_assembler #(
    .SAMPLE_WIDTH    (SAMPLE_WIDTH),
    .SAMPLES_PER_WORD(SAMPLES_PER_WORD)
  ) u_asm (
    .clk     (clk),
    .reset   (reset),
    .in_data (in_data),
    .in_valid(in_valid),
    .flush   (flush),
    .word    (word),
    .done    (done),
    .lane    (lane)
  );

  assign fifo_wr_en   = pend_valid & ~fifo_full;
  assign fifo_wr_data = pend_word;
  assign busy         = (lane != '0) | pend_valid;
  // A new word is dropped only when the held word cannot leave this cycle.
  assign drop         = done & pend_valid & ~fifo_wr_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_word  <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      word_count <= '0;
    end else begin
      if (done && !drop) begin
        pend_word  <= word;
        pend_valid <= 1'b1;
      end else if (fifo_wr_en) begin
        pend_valid <= 1'b0;
      end

      if (fifo_wr_en) word_count <= word_count + CNT_WIDTH'(1);

      if (clear_status) begin
        overflow   <= drop;
        drop_count <= drop ? CNT_WIDTH'(1) : '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_fifo_sample_packer.sv
// Directed checks of the sample packer at SAMPLES_PER_WORD = 2, 4 and 1.
module tb_fifo_sample_packer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // SPW=2 instance
  logic        rst2, v2, fl2, cs2, full2, we2, ov2, bz2;
  logic [15:0] d2, dc2, wc2;
  logic [31:0] wd2;
  // SPW=4 instance
  logic        rst4, v4, fl4, cs4, full4, we4, ov4, bz4;
  logic [15:0] d4, dc4, wc4;
  logic [63:0] wd4;
  // SPW=1 instance
  logic        rst1, v1, fl1, cs1, full1, we1, ov1, bz1;
  logic [15:0] d1, dc1, wc1;
  logic [15:0] wd1;

  fifo_sample_packer #(.SAMPLE_WIDTH(16), .SAMPLES_PER_WORD(2), .CNT_WIDTH(16)) u2 (
    .clk(clk), .reset(rst2), .in_data(d2), .in_valid(v2), .flush(fl2), .clear_status(cs2),
    .fifo_wr_data(wd2), .fifo_wr_en(we2), .fifo_full(full2), .overflow(ov2),
    .drop_count(dc2), .word_count(wc2), .busy(bz2));

  fifo_sample_packer #(.SAMPLE_WIDTH(16), .SAMPLES_PER_WORD(4), .CNT_WIDTH(16)) u4 (
    .clk(clk), .reset(rst4), .in_data(d4), .in_valid(v4), .flush(fl4), .clear_status(cs4),
    .fifo_wr_data(wd4), .fifo_wr_en(we4), .fifo_full(full4), .overflow(ov4),
    .drop_count(dc4), .word_count(wc4), .busy(bz4));

  fifo_sample_packer #(.SAMPLE_WIDTH(16), .SAMPLES_PER_WORD(1), .CNT_WIDTH(16)) u1 (
    .clk(clk), .reset(rst1), .in_data(d1), .in_valid(v1), .flush(fl1), .clear_status(cs1),
    .fifo_wr_data(wd1), .fifo_wr_en(we1), .fifo_full(full1), .overflow(ov1),
    .drop_count(dc1), .word_count(wc1), .busy(bz1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    {rst2, rst4, rst1} = 3'b111;
    {v2, fl2, cs2, full2} = '0; d2 = '0;
    {v4, fl4, cs4, full4} = '0; d4 = '0;
    {v1, fl1, cs1, full1} = '0; d1 = '0;
    tick(); tick();
    {rst2, rst4, rst1} = 3'b000;
    checks++; if ({we2, bz2, ov2} !== 3'b000) begin failures++; $display("FAIL reset_flags2 got=%b exp=000", {we2, bz2, ov2}); end
    checks++; if ({dc2, wc2} !== 32'h0) begin failures++; $display("FAIL reset_cnt2 got=%h exp=0", {dc2, wc2}); end
    checks++; if ({we4, bz4, we1, bz1} !== 4'b0000) begin failures++; $display("FAIL reset_flags41 got=%b exp=0000", {we4, bz4, we1, bz1}); end
  endtask

  task automatic test_basic_pack();
    d2 = 16'h1111; v2 = 1; tick();
    d2 = 16'h2222; tick();
    d2 = 16'h3333;
    checks++; if (we2 !== 1'b1 || wd2 !== 32'h22221111) begin failures++; $display("FAIL basic_w0 got=%b/%h exp=1/22221111", we2, wd2); end
    tick();
    checks++; if (we2 !== 1'b0) begin failures++; $display("FAIL basic_gap got=%b exp=0", we2); end
    d2 = 16'h4444; tick();
    v2 = 0;
    checks++; if (we2 !== 1'b1 || wd2 !== 32'h44443333) begin failures++; $display("FAIL basic_w1 got=%b/%h exp=1/44443333", we2, wd2); end
    tick();
    checks++; if (we2 !== 1'b0 || wc2 !== 16'd2 || bz2 !== 1'b0) begin failures++; $display("FAIL basic_end got=%b/%0d/%b exp=0/2/0", we2, wc2, bz2); end
  endtask

  task automatic test_flush();
    d4 = 16'hAAAA; v4 = 1; tick();
    d4 = 16'hBBBB; tick();
    v4 = 0; fl4 = 1; tick();
    fl4 = 0;
    checks++; if (we4 !== 1'b1 || wd4 !== 64'h0000_0000_BBBB_AAAA) begin failures++; $display("FAIL flush_word got=%b/%h exp=1/00000000bbbbaaaa", we4, wd4); end
    tick();
    checks++; if (we4 !== 1'b0 || bz4 !== 1'b0) begin failures++; $display("FAIL flush_idle got=%b/%b exp=0/0", we4, bz4); end
    fl4 = 1; tick();
    fl4 = 0;
    checks++; if (we4 !== 1'b0 || wc4 !== 16'd1) begin failures++; $display("FAIL flush_empty got=%b/%0d exp=0/1", we4, wc4); end
  endtask

  task automatic test_backpressure();
    full2 = 1; d2 = 16'h7777; v2 = 1; tick();
    d2 = 16'h8888; tick();
    v2 = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (we2 !== 1'b0 || bz2 !== 1'b1) begin failures++; $display("FAIL bp_hold%0d got=%b/%b exp=0/1", i, we2, bz2); end
      tick();
    end
    full2 = 0; #1;
    checks++; if (we2 !== 1'b1 || wd2 !== 32'h88887777) begin failures++; $display("FAIL bp_release got=%b/%h exp=1/88887777", we2, wd2); end
    tick();
    checks++; if ({we2, ov2} !== 2'b00 || dc2 !== 16'd0 || wc2 !== 16'd3) begin failures++; $display("FAIL bp_after got=%b%b/%0d/%0d exp=00/0/3", we2, ov2, dc2, wc2); end
  endtask

  task automatic test_overflow();
    full1 = 1; d1 = 16'h0001; v1 = 1; tick();
    d1 = 16'h0002; tick();
    d1 = 16'h0003; tick();
    v1 = 0;
    checks++; if (wd1 !== 16'h0001 || we1 !== 1'b0) begin failures++; $display("FAIL ovf_pend got=%h/%b exp=0001/0", wd1, we1); end
    checks++; if (dc1 !== 16'd2 || ov1 !== 1'b1) begin failures++; $display("FAIL ovf_status got=%0d/%b exp=2/1", dc1, ov1); end
    full1 = 0; #1;
    checks++; if (we1 !== 1'b1 || wd1 !== 16'h0001) begin failures++; $display("FAIL ovf_write got=%b/%h exp=1/0001", we1, wd1); end
    tick();
    checks++; if (we1 !== 1'b0 || wc1 !== 16'd1) begin failures++; $display("FAIL ovf_once got=%b/%0d exp=0/1", we1, wc1); end
    tick();
    checks++; if (we1 !== 1'b0 || bz1 !== 1'b0) begin failures++; $display("FAIL ovf_idle got=%b/%b exp=0/0", we1, bz1); end
  endtask

  task automatic test_clear_collision();
    full1 = 1; d1 = 16'h0009; v1 = 1; tick();
    d1 = 16'h000A; cs1 = 1; tick();
    v1 = 0; cs1 = 0;
    checks++; if (dc1 !== 16'd1 || ov1 !== 1'b1) begin failures++; $display("FAIL clr_collide got=%0d/%b exp=1/1", dc1, ov1); end
    cs1 = 1; tick();
    cs1 = 0;
    checks++; if (dc1 !== 16'd0 || ov1 !== 1'b0) begin failures++; $display("FAIL clr_alone got=%0d/%b exp=0/0", dc1, ov1); end
    full1 = 0; #1;
    checks++; if (we1 !== 1'b1 || wd1 !== 16'h0009) begin failures++; $display("FAIL clr_drain got=%b/%h exp=1/0009", we1, wd1); end
    tick();
  endtask

  task automatic test_back_to_back();
    v1 = 1;
    for (int i = 0; i < 4; i++) begin
      d1 = 16'h0011 + 16'(i); tick();
      checks++; if (we1 !== 1'b1 || wd1 !== 16'h0011 + 16'(i)) begin failures++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i, we1, wd1, 16'h0011 + 16'(i)); end
    end
    v1 = 0; tick();
    checks++; if (we1 !== 1'b0 || wc1 !== 16'd6) begin failures++; $display("FAIL b2b_end got=%b/%0d exp=0/6", we1, wc1); end
  endtask

  task automatic test_reset_mid();
    full2 = 1; d2 = 16'h0001; v2 = 1; tick();
    d2 = 16'h0002; tick();
    d2 = 16'h0003; tick();
    v2 = 0; full2 = 0; rst2 = 1; tick();
    rst2 = 0;
    checks++; if ({we2, bz2, ov2} !== 3'b000 || dc2 !== 16'd0 || wc2 !== 16'd0) begin failures++; $display("FAIL rstmid_state got=%b%b%b/%0d/%0d exp=000/0/0", we2, bz2, ov2, dc2, wc2); end
    d2 = 16'h5555; v2 = 1; tick();
    d2 = 16'h6666; tick();
    v2 = 0;
    checks++; if (we2 !== 1'b1 || wd2 !== 32'h66665555) begin failures++; $display("FAIL rstmid_word got=%b/%h exp=1/66665555", we2, wd2); end
    tick();
    checks++; if (dc2 !== 16'd0 || wc2 !== 16'd1) begin failures++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/1", dc2, wc2); end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_flush();
    test_backpressure();
    test_overflow();
    test_clear_collision();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
